reorder_buffer: RTL

In-order reorder buffer (ROB) for the out-of-order backend. It allocates entries at issue, accepts result writebacks from the ALU, MEM and MUL pipes, and retires completed entries in program order to the register file. It is the producer side of the operand forwarding path: it answers the forward unit's `rs1_rob_entry`/`rs2_rob_entry` lookups with `rob_s*_data`/`rob_s*_valid`.

---
 rtl/rob_pkg.sv | 18 +
 rtl/reorder_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and default sizing, imported by the ROB,
// forward unit and issue logic.
package rob_pkg;

    localparam int ROB_WORD_W = 32;
    localparam int ROB_ID_W   = 3;
    localparam int ROB_RD_W   = 5;
    localparam int ROB_DEPTH  = 1 << ROB_ID_W;

    typedef struct packed {
        logic                  busy;
        logic                  ready;
        logic                  has_dest;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_WORD_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at issue, collects ALU/MEM/MUL results,
// retires in program order and serves operand lookups for forwarding.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int WORD_SIZE       = ROB_WORD_W,
    parameter int ROB_ENTRY_WIDTH = ROB_ID_W,
    parameter int REG_ADDR_WIDTH  = ROB_RD_W
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       alloc_valid,
    input  logic                       alloc_has_dest,
    input  logic [REG_ADDR_WIDTH-1:0]  alloc_rd,
    output logic                       alloc_ready,
    output logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,

    input  logic                       alu_wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       alu_wb_data,
    input  logic                       mem_wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       mem_wb_data,
    input  logic                       mul_wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
    input  logic [WORD_SIZE-1:0]       mul_wb_data,

    input  logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry,
    input  logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry,
    output logic [WORD_SIZE-1:0]       rob_s1_data,
    output logic [WORD_SIZE-1:0]       rob_s2_data,
    output logic                       rob_s1_valid,
    output logic                       rob_s2_valid,

    output logic                       commit_valid,
    output logic                       commit_we,
    output logic [REG_ADDR_WIDTH-1:0]  commit_rd,
    output logic [WORD_SIZE-1:0]       commit_data,
    output logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,

    input  logic                       flush,
    output logic                       rob_empty,
    output logic                       rob_full
);

    localparam int DEPTH = 1 << ROB_ENTRY_WIDTH;
    localparam logic [ROB_ENTRY_WIDTH:0]   CNT_FULL = (ROB_ENTRY_WIDTH+1)'(DEPTH);
    localparam logic [ROB_ENTRY_WIDTH:0]   CNT_ONE  = (ROB_ENTRY_WIDTH+1)'(1);
    localparam logic [ROB_ENTRY_WIDTH-1:0] PTR_ONE  = ROB_ENTRY_WIDTH'(1);

    typedef struct packed {
        logic                      busy;
        logic                      ready;
        logic                      has_dest;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [WORD_SIZE-1:0]      data;
    } entry_t;

    entry_t                     entries_q [DEPTH];
    entry_t                     entries_d [DEPTH];
    logic [ROB_ENTRY_WIDTH-1:0] head_q, head_d;
    logic [ROB_ENTRY_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_ENTRY_WIDTH:0]   count_q, count_d;

    logic do_alloc;
    logic do_commit;

    assign rob_full     = (count_q == CNT_FULL);
    assign rob_empty    = (count_q == '0);
    assign alloc_ready  = !rob_full && !flush;
    assign alloc_rob_id = tail_q;
    assign do_alloc     = alloc_valid && alloc_ready;

    assign do_commit     = !flush && entries_q[head_q].busy && entries_q[head_q].ready;
    assign commit_valid  = do_commit;
    assign commit_we     = do_commit && entries_q[head_q].has_dest;
    assign commit_rd     = entries_q[head_q].rd;
    assign commit_data   = entries_q[head_q].data;
    assign commit_rob_id = head_q;

    assign rob_s1_data  = entries_q[rs1_rob_entry].data;
    assign rob_s1_valid = entries_q[rs1_rob_entry].busy && entries_q[rs1_rob_entry].ready;
    assign rob_s2_data  = entries_q[rs2_rob_entry].data;
    assign rob_s2_valid = entries_q[rs2_rob_entry].busy && entries_q[rs2_rob_entry].ready;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].busy  = 1'b0;
                entries_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Lowest priority first so ALU overwrites MEM/MUL on a shared id.
            if (mul_wb_valid && entries_q[mul_wb_rob_id].busy) begin
                entries_d[mul_wb_rob_id].ready = 1'b1;
                entries_d[mul_wb_rob_id].data  = mul_wb_data;
            end
            if (mem_wb_valid && entries_q[mem_wb_rob_id].busy) begin
                entries_d[mem_wb_rob_id].ready = 1'b1;
                entries_d[mem_wb_rob_id].data  = mem_wb_data;
            end
            if (alu_wb_valid && entries_q[alu_wb_rob_id].busy) begin
                entries_d[alu_wb_rob_id].ready = 1'b1;
                entries_d[alu_wb_rob_id].data  = alu_wb_data;
            end

            if (do_alloc) begin
                entries_d[tail_q].busy     = 1'b1;
                entries_d[tail_q].ready    = 1'b0;
                entries_d[tail_q].has_dest = alloc_has_dest;
                entries_d[tail_q].rd       = alloc_rd;
                tail_d = tail_q + PTR_ONE;
            end

            if (do_commit) begin
                entries_d[head_q].busy = 1'b0;
                head_d = head_q + PTR_ONE;
            end

            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule
